// File: rtl/sdram_port_arbiter_if.sv
// Client-side burst request bundle for sdram_port_arbiter; one instance per client.
// The client drives the master modport, the arbiter receives the slave modport.
interface sdram_port_arbiter_if #(
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int APP_BURST_WIDTH = 10,
  parameter int SDR_DQ_WIDTH    = 16
);
  logic                       req;
  logic                       we;
  logic [APP_ADDR_WIDTH-1:0]  addr;
  logic [APP_BURST_WIDTH-1:0] len;
  logic [SDR_DQ_WIDTH-1:0]    wr_data;
  logic                       ack;
  logic                       wr_data_req;
  logic                       rd_data_valid;
  logic                       done;

  modport master (
    output req, we, addr, len, wr_data,
    input  ack, wr_data_req, rd_data_valid, done
  );

  modport slave (
    input  req, we, addr, len, wr_data,
    output ack, wr_data_req, rd_data_valid, done
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin arbiter in front of the sdram_core burst interface.
// One burst at a time, latched address/length, data handshakes routed to the grantee, per-burst watchdog.
module sdram_port_arbiter #(
  parameter int APP_ADDR_WIDTH  = 24,
  parameter int APP_BURST_WIDTH = 10,
  parameter int SDR_DQ_WIDTH    = 16,
  parameter int TIMEOUT         = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  sdram_port_arbiter_if.slave        p0_if,
  sdram_port_arbiter_if.slave        p1_if,
  output logic                       wr_burst_req_o,
  output logic [APP_BURST_WIDTH-1:0] wr_burst_len_o,
  output logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr_o,
  output logic [SDR_DQ_WIDTH-1:0]    wr_burst_data_o,
  input  logic                       wr_burst_data_req_i,
  input  logic                       wr_burst_finish_i,
  output logic                       rd_burst_req_o,
  output logic [APP_BURST_WIDTH-1:0] rd_burst_len_o,
  output logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr_o,
  input  logic                       rd_burst_data_valid_i,
  input  logic                       rd_burst_finish_i,
  output logic                       timeout_err_o,
  output logic                       grant_id_o
);

  localparam int                CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_BUSY,
    RD_BUSY
  } state_e;

  state_e                     state_q;
  logic [1:0]                 ack_q;
  logic [1:0]                 done_q;
  logic                       wr_req_q;
  logic                       rd_req_q;
  logic                       grant_q;
  logic                       last_grant_q;
  logic                       timeout_err_q;
  logic [APP_ADDR_WIDTH-1:0]  addr_q;
  logic [APP_BURST_WIDTH-1:0] len_q;
  logic [CNT_W-1:0]           wdog_q;

  logic [1:0]                 req_v;
  logic                       grant_d;
  logic                       grant_we;
  logic [APP_ADDR_WIDTH-1:0]  grant_addr;
  logic [APP_BURST_WIDTH-1:0] grant_len;
  logic                       finish_cur;
  logic                       wdog_expired;
  logic                       wr_fwd;
  logic                       rd_fwd;

  // A port whose ack is on the wire this cycle still shows req; masking it stops a
  // zero-length request from being granted twice.
  assign req_v        = {p1_if.req & ~ack_q[1], p0_if.req & ~ack_q[0]};
  assign grant_d      = (req_v == 2'b11) ? ~last_grant_q : req_v[1];
  assign grant_we     = grant_d ? p1_if.we   : p0_if.we;
  assign grant_addr   = grant_d ? p1_if.addr : p0_if.addr;
  assign grant_len    = grant_d ? p1_if.len  : p0_if.len;
  assign finish_cur   = (state_q == WR_BUSY) ? wr_burst_finish_i : rd_burst_finish_i;
  assign wdog_expired = (wdog_q == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ack_q         <= '0;
      done_q        <= '0;
      wr_req_q      <= 1'b0;
      rd_req_q      <= 1'b0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      timeout_err_q <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      wdog_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below sees the
      // register values from the start of the cycle regardless of statement order.
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req_v) begin
            ack_q[grant_d] <= 1'b1;
            grant_q        <= grant_d;
            last_grant_q   <= grant_d;
            addr_q         <= grant_addr;
            len_q          <= grant_len;
            if (grant_len == '0) begin
              done_q[grant_d] <= 1'b1;
            end else begin
              wdog_q <= '0;
              if (grant_we) begin
                state_q  <= WR_BUSY;
                wr_req_q <= 1'b1;
              end else begin
                state_q  <= RD_BUSY;
                rd_req_q <= 1'b1;
              end
            end
          end
        end
        WR_BUSY, RD_BUSY: begin
          wdog_q <= wdog_q + CNT_W'(1);
          // A finish coinciding with expiry is a normal completion.
          if (finish_cur || wdog_expired) begin
            state_q         <= IDLE;
            wr_req_q        <= 1'b0;
            rd_req_q        <= 1'b0;
            done_q[grant_q] <= 1'b1;
            if (!finish_cur) timeout_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Core handshakes only reach the grantee, and only while its burst is live.
  assign wr_fwd = wr_req_q & wr_burst_data_req_i;
  assign rd_fwd = rd_req_q & rd_burst_data_valid_i;

  assign p0_if.ack           = ack_q[0];
  assign p1_if.ack           = ack_q[1];
  assign p0_if.done          = done_q[0];
  assign p1_if.done          = done_q[1];
  assign p0_if.wr_data_req   = wr_fwd & ~grant_q;
  assign p1_if.wr_data_req   = wr_fwd &  grant_q;
  assign p0_if.rd_data_valid = rd_fwd & ~grant_q;
  assign p1_if.rd_data_valid = rd_fwd &  grant_q;

  assign wr_burst_req_o  = wr_req_q;
  assign wr_burst_len_o  = wr_req_q ? len_q  : '0;
  assign wr_burst_addr_o = wr_req_q ? addr_q : '0;
  assign wr_burst_data_o = wr_req_q ? (grant_q ? p1_if.wr_data : p0_if.wr_data) : '0;
  assign rd_burst_req_o  = rd_req_q;
  assign rd_burst_len_o  = rd_req_q ? len_q  : '0;
  assign rd_burst_addr_o = rd_req_q ? addr_q : '0;
  assign timeout_err_o   = timeout_err_q;
  assign grant_id_o      = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected bursts are queued at issue time and
// retired on each done pulse; a small core model answers the burst requests.
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int BW = 10;
  localparam int DW = 16;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(BW), .SDR_DQ_WIDTH(DW)) p0_if ();
  sdram_port_arbiter_if #(.APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(BW), .SDR_DQ_WIDTH(DW)) p1_if ();

  logic          wr_burst_req;
  logic [BW-1:0] wr_burst_len;
  logic [AW-1:0] wr_burst_addr;
  logic [DW-1:0] wr_burst_data;
  logic          wr_burst_data_req;
  logic          wr_burst_finish;
  logic          rd_burst_req;
  logic [BW-1:0] rd_burst_len;
  logic [AW-1:0] rd_burst_addr;
  logic          rd_burst_data_valid;
  logic          rd_burst_finish;
  logic          timeout_err;
  logic          grant_id;

  sdram_port_arbiter #(
    .APP_ADDR_WIDTH (AW),
    .APP_BURST_WIDTH(BW),
    .SDR_DQ_WIDTH   (DW),
    .TIMEOUT        (TO)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .p0_if                (p0_if),
    .p1_if                (p1_if),
    .wr_burst_req_o       (wr_burst_req),
    .wr_burst_len_o       (wr_burst_len),
    .wr_burst_addr_o      (wr_burst_addr),
    .wr_burst_data_o      (wr_burst_data),
    .wr_burst_data_req_i  (wr_burst_data_req),
    .wr_burst_finish_i    (wr_burst_finish),
    .rd_burst_req_o       (rd_burst_req),
    .rd_burst_len_o       (rd_burst_len),
    .rd_burst_addr_o      (rd_burst_addr),
    .rd_burst_data_valid_i(rd_burst_data_valid),
    .rd_burst_finish_i    (rd_burst_finish),
    .timeout_err_o        (timeout_err),
    .grant_id_o           (grant_id)
  );

  typedef struct {
    bit          port;
    bit          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] len;
    int          ack_at;   // absolute ack cycle, or -1 for "cycle after previous done"
    int          busy;     // cycles the core request stays high
    int          nfwd;     // data handshakes the grantee should see
    bit          terr;     // timeout_err level at done
  } exp_t;

  exp_t exp_q[$];

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int last_done  = -100;
  int ack_cyc    = 0;
  int busy_cnt   = 0;
  int stray      = 0;
  int fwd[2];
  bit fields_bad = 0;
  bit data_bad   = 0;
  bit core_stall = 0;
  int core_cnt   = 0;
  bit core_fin   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({p0_if.ack, p0_if.wr_data_req, p0_if.rd_data_valid, p0_if.done,
                 p1_if.ack, p1_if.wr_data_req, p1_if.rd_data_valid, p1_if.done,
                 wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
                 rd_burst_req, rd_burst_len, rd_burst_addr, timeout_err, grant_id});
  endfunction

  task automatic issue(input bit port, input bit we, input logic [AW-1:0] addr,
                       input logic [BW-1:0] len, input bit queued, input bit terr);
    exp_t e;
    e.port   = port;
    e.we     = we;
    e.addr   = addr;
    e.len    = len;
    e.ack_at = queued ? -1 : cyc + 1;
    e.busy   = (len == 0) ? 0 : (core_stall ? TO : int'(len) + 1);
    e.nfwd   = (len == 0 || core_stall) ? 0 : int'(len);
    e.terr   = terr;
    if (port) begin
      p1_if.req = 1'b1; p1_if.we = we; p1_if.addr = addr; p1_if.len = len;
    end else begin
      p0_if.req = 1'b1; p0_if.we = we; p0_if.addr = addr; p0_if.len = len;
    end
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t       e;
    logic [1:0] acks;
    logic [1:0] dones;
    acks  = {p1_if.ack, p0_if.ack};
    dones = {p1_if.done, p0_if.done};
    if (acks != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 128'(acks), 128'(0));
      end else begin
        e = exp_q[0];
        check("ack_port", 128'(acks), e.port ? 128'(2) : 128'(1));
        check("ack_cycle", 128'(cyc), 128'(e.ack_at >= 0 ? e.ack_at : last_done + 1));
        ack_cyc = cyc; busy_cnt = 0; fwd[0] = 0; fwd[1] = 0;
        fields_bad = 0; data_bad = 0;
      end
    end
    if (wr_burst_req || rd_burst_req) begin
      check("one_core_req", 128'(wr_burst_req & rd_burst_req), 128'(0));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        busy_cnt++;
        if (wr_burst_req != e.we) fields_bad = 1;
        if (wr_burst_req && (wr_burst_addr != e.addr || wr_burst_len != e.len)) fields_bad = 1;
        if (rd_burst_req && (rd_burst_addr != e.addr || rd_burst_len != e.len)) fields_bad = 1;
        if (wr_burst_req && wr_burst_data_req &&
            wr_burst_data != (e.port ? p1_if.wr_data : p0_if.wr_data)) data_bad = 1;
      end
    end else if ({p0_if.wr_data_req, p0_if.rd_data_valid,
                  p1_if.wr_data_req, p1_if.rd_data_valid} != 4'b0000) begin
      stray++;
    end
    fwd[0] += int'(p0_if.wr_data_req) + int'(p0_if.rd_data_valid);
    fwd[1] += int'(p1_if.wr_data_req) + int'(p1_if.rd_data_valid);
    if (dones != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 128'(dones), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("done_port", 128'(dones), e.port ? 128'(2) : 128'(1));
        check("done_cycle", 128'(cyc), 128'(ack_cyc + e.busy));
        check("busy_cycles", 128'(busy_cnt), 128'(e.busy));
        check("fwd_grantee", 128'(fwd[e.port ? 1 : 0]), 128'(e.nfwd));
        check("fwd_other", 128'(fwd[e.port ? 0 : 1]), 128'(0));
        check("core_fields", 128'(fields_bad), 128'(0));
        check("wr_data_mux", 128'(data_bad), 128'(0));
        check("timeout_err", 128'(timeout_err), 128'(e.terr));
        check("grant_id", 128'(grant_id), 128'(e.port));
        last_done = cyc;
      end
    end
  endtask

  // One clock: clients and core react just after the edge, outputs sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (p0_if.ack) begin
      p0_if.req = 1'b0; p0_if.addr = AW'($urandom); p0_if.len = BW'($urandom);
    end
    if (p1_if.ack) begin
      p1_if.req = 1'b0; p1_if.addr = AW'($urandom); p1_if.len = BW'($urandom);
    end
    p0_if.wr_data = DW'($urandom);
    p1_if.wr_data = DW'($urandom);
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    if (wr_burst_req || rd_burst_req) begin
      if (!core_stall) begin
        if (core_cnt < int'(wr_burst_req ? wr_burst_len : rd_burst_len)) begin
          if (wr_burst_req) wr_burst_data_req = 1'b1; else rd_burst_data_valid = 1'b1;
          core_cnt++;
        end else if (!core_fin) begin
          if (wr_burst_req) wr_burst_finish = 1'b1; else rd_burst_finish = 1'b1;
          core_fin = 1;
        end
      end
    end else begin
      core_cnt = 0;
      core_fin = 0;
      {wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish} = 4'($urandom);
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.len = '0; p0_if.wr_data = '0;
    p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.len = '0; p1_if.wr_data = '0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_finish = 1'b0;
    fwd[0] = 0; fwd[1] = 0;
    repeat (3) tick();
    check("reset_outputs", outs(), 128'(0));
    rst = 1'b0;
    tick();

    // Single p0 write of 8 words.
    issue(1'b0, 1'b1, 24'h000100, 10'd8, 1'b0, 1'b0);
    wait_empty(100);

    // p1 read of 4 words; p1 scrambles its address after ack.
    issue(1'b1, 1'b0, 24'h0A0B0C, 10'd4, 1'b0, 1'b0);
    wait_empty(100);

    // Simultaneous reads, twice: p0 first each time, p1 right after p0's done.
    issue(1'b0, 1'b0, 24'h111111, 10'd3, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 24'h222222, 10'd5, 1'b1, 1'b0);
    wait_empty(100);
    issue(1'b0, 1'b0, 24'h333333, 10'd2, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 24'h444444, 10'd1, 1'b1, 1'b0);
    wait_empty(100);

    // Core never finishes: watchdog abort after TO busy cycles.
    core_stall = 1;
    issue(1'b0, 1'b1, 24'h000200, 10'd8, 1'b0, 1'b1);
    wait_empty(100);
    core_stall = 0;

    // p1 write; p0 requests briefly while busy and withdraws before any ack.
    issue(1'b1, 1'b1, 24'h00ABCD, 10'd6, 1'b0, 1'b1);
    tick();
    tick();
    p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.len = 10'd5;
    tick();
    tick();
    p0_if.req = 1'b0;
    wait_empty(100);

    // Zero-length request: ack and done together, core untouched.
    issue(1'b0, 1'b1, 24'h000300, 10'd0, 1'b0, 1'b1);
    wait_empty(20);

    // Reset in the middle of a read burst.
    issue(1'b1, 1'b0, 24'h00F00D, 10'd40, 1'b0, 1'b1);
    n = 0;
    while (!rd_burst_req && n < 10) begin
      tick();
      n++;
    end
    check("rd_req_before_rst", 128'(rd_burst_req), 128'(1));
    repeat (3) tick();
    check("terr_sticky", 128'(timeout_err), 128'(1));
    rst = 1'b1;
    tick();
    check("mid_burst_reset_outputs", outs(), 128'(0));
    exp_q.delete();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_after_reset", 128'({wr_burst_req, rd_burst_req, timeout_err}), 128'(0));

    // Tie right after reset goes to p0; both zero-length.
    issue(1'b0, 1'b1, 24'h000010, 10'd0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 24'h000020, 10'd0, 1'b1, 1'b0);
    wait_empty(20);

    check("stray_forward", 128'(stray), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
